pc_redirect_controller: RTL and testbench
=========================================

PC_REDIRECT_CONTROLLER -- requirements
Module: pc_redirect_controller

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock, rising edge.
REQ-002 SHALL have ports: RESET  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: ex_valid  in  1  EX-stage instruction valid.
REQ-004 SHALL have ports: branch_jump_mux_signal  in  1  EX branch taken or jump.
REQ-005 SHALL have ports: jump_signal  in  1  EX instruction is a jump.
REQ-006 SHALL have ports: Branch_jump_PC_OUT  in  32  resolved target.
REQ-007 SHALL have ports: imem_busy  in  1  instruction memory cannot accept a new fetch address.
REQ-008 SHALL have ports: pc_load  out  1  PC takes pc_target this cycle.
REQ-009 SHALL have ports: pc_target  out  32  redirect address.
REQ-010 SHALL have ports: flush_if_id  out  1  invalidate IF/ID register.
REQ-011 SHALL have ports: flush_id_ex  out  1  invalidate ID/EX register.
REQ-012 SHALL have ports: misalign_trap  out  1  one-cycle pulse, target not word aligned.
REQ-013 SHALL have ports: busy  out  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement a four-state machine: IDLE, PENDING, REDIRECT, SHADOW.
REQ-015 SHALL define taken = ex_valid & branch_jump_mux_signal, sampled at the rising CLK edge, in IDLE only.
REQ-016 SHALL ignore taken in PENDING, REDIRECT and SHADOW, because those instructions are wrong-path.
REQ-017 IDLE: on taken with Branch_jump_PC_OUT[1:0]==00, SHALL latch the target.
REQ-018 IDLE: after latching, SHALL go to REDIRECT if imem_busy=0, else to PENDING.
REQ-019 IDLE: on taken with Branch_jump_PC_OUT[1:0]!=00, SHALL pulse misalign_trap for the next cycle and remain IDLE with no redirect.
REQ-020 PENDING: SHALL hold the latched target and assert flush_id_ex every cycle.
REQ-021 PENDING: SHALL go to REDIRECT on the first edge with imem_busy=0.
REQ-022 REDIRECT: SHALL assert pc_load, flush_if_id and flush_id_ex for exactly one cycle, with pc_target equal to the latched target, then go to SHADOW.
REQ-023 SHADOW: SHALL assert flush_if_id only, for exactly one cycle, to discard the in-flight fetch, then go to IDLE.
REQ-024 Latency, taken in EX to pc_load: 1 cycle when imem_busy=0, otherwise 1 plus the number of busy cycles.
REQ-025 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-026 Outside REDIRECT, pc_target SHALL hold its last latched value and pc_load SHALL be 0.
REQ-027 Back-to-back taken instructions SHALL produce exactly one redirect; the younger one is flushed.

Reset
REQ-028 While RESET=0, SHALL force state IDLE and drive all outputs to 0, including pc_target=32'h0, independent of CLK.
REQ-029 Reset asserted in PENDING, REDIRECT or SHADOW SHALL discard the latched target; no pc_load SHALL follow deassertion.
REQ-030 The first edge after RESET rises SHALL evaluate taken normally.

Configuration
REQ-031 With macro REDIRECT_STATS_EN defined, SHALL add outputs branch_count [31:0] and jump_count [31:0].
REQ-032 The counters SHALL increment by 1 on each entry to REDIRECT, selected by the jump_signal value latched with the target.
REQ-033 The counters SHALL reset to 0 and wrap from 32'hFFFFFFFF to 0.
REQ-034 Without REDIRECT_STATS_EN, these ports and counters SHALL be absent, and the remaining behaviour SHALL be identical.

Verification
REQ-035 Taken branch, target 32'h0000_0100, imem_busy=0 -> next cycle pc_load=1, pc_target=32'h100, both flushes=1; following cycle flush_if_id=1 only; then IDLE.
REQ-036 Taken with imem_busy=1 for 3 cycles, target 32'h200 -> flush_id_ex high for 3 cycles, then REDIRECT with pc_target=32'h200.
REQ-037 Taken on two consecutive cycles (targets 32'h40 then 32'h80) -> single pc_load with pc_target=32'h40.
REQ-038 Taken jump, target 32'h0000_0102 -> misalign_trap=1 for one cycle, pc_load stays 0, busy stays 0.
REQ-039 RESET driven low mid-PENDING -> outputs 0 immediately; after release, no pc_load occurs without a new taken.
REQ-040 With REDIRECT_STATS_EN: 2 branches plus 1 jump redirected -> branch_count=2, jump_count=1; a preload of 32'hFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/pc_redirect_controller.sv
// pc_redirect_controller: registered EX-stage redirect FSM (IDLE/PENDING/REDIRECT/SHADOW).
// Optional branch/jump redirect counters when REDIRECT_STATS_EN is defined.
module pc_redirect_controller (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ex_valid,
    input  logic        branch_jump_mux_signal,
    input  logic        jump_signal,
    input  logic [31:0] Branch_jump_PC_OUT,
    input  logic        imem_busy,
    output logic        pc_load,
    output logic [31:0] pc_target,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        misalign_trap,
    output logic        busy
`ifdef REDIRECT_STATS_EN
    ,
    output logic [31:0] branch_count,
    output logic [31:0] jump_count
`endif
);
    typedef enum logic [1:0] {IDLE, PENDING, REDIRECT, SHADOW} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_target;
    logic        w_taken;
    logic        w_aligned;
    logic        w_launch;

    assign w_taken   = ex_valid & branch_jump_mux_signal;
    assign w_aligned = Branch_jump_PC_OUT[1:0] == 2'b00;
    assign w_launch  = (r_state == IDLE) & w_taken & w_aligned;

    // Taken is only honoured in IDLE; everything seen in later states is wrong-path.
    assign w_next = (r_state == IDLE)     ? (w_launch ? (imem_busy ? PENDING : REDIRECT) : IDLE) :
                    (r_state == PENDING)  ? (imem_busy ? PENDING : REDIRECT) :
                    (r_state == REDIRECT) ? SHADOW : IDLE;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state       <= IDLE;
            r_target      <= '0;
            pc_target     <= '0;
            pc_load       <= 1'b0;
            flush_if_id   <= 1'b0;
            flush_id_ex   <= 1'b0;
            misalign_trap <= 1'b0;
            busy          <= 1'b0;
        end else begin
            r_state       <= w_next;
            if (w_launch)
                r_target <= Branch_jump_PC_OUT;
            if (w_next == REDIRECT)
                pc_target <= (r_state == IDLE) ? Branch_jump_PC_OUT : r_target;
            pc_load       <= w_next == REDIRECT;
            flush_if_id   <= (w_next == REDIRECT) | (w_next == SHADOW);
            flush_id_ex   <= (w_next == REDIRECT) | (w_next == PENDING);
            misalign_trap <= (r_state == IDLE) & w_taken & ~w_aligned;
            busy          <= w_next != IDLE;
        end
    end

`ifdef REDIRECT_STATS_EN
    logic r_jump;
    logic w_jump;

    assign w_jump = (r_state == IDLE) ? jump_signal : r_jump;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_jump       <= 1'b0;
            branch_count <= '0;
            jump_count   <= '0;
        end else begin
            if (w_launch)
                r_jump <= jump_signal;
            if (w_next == REDIRECT) begin
                if (w_jump)
                    jump_count <= jump_count + 32'd1;
                else
                    branch_count <= branch_count + 32'd1;
            end
        end
    end
`else
    logic w_unused_jump;
    assign w_unused_jump = jump_signal;
`endif
endmodule

// File: tb/tb_pc_redirect_controller.sv
// tb_pc_redirect_controller: scoreboard bench; expected outputs are queued per driven cycle.
// Counter checks are compiled only when REDIRECT_STATS_EN is defined.
module tb_pc_redirect_controller;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        bj = 1'b0;
    logic        js = 1'b0;
    logic [31:0] tgt = '0;
    logic        ib = 1'b0;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        misalign_trap;
    logic        busy;
`ifdef REDIRECT_STATS_EN
    logic [31:0] branch_count;
    logic [31:0] jump_count;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [36:0] v;
    } exp_t;
    exp_t q[$];

    pc_redirect_controller dut (
        .CLK                    (clk),
        .RESET                  (rst_n),
        .ex_valid               (ex_valid),
        .branch_jump_mux_signal (bj),
        .jump_signal            (js),
        .Branch_jump_PC_OUT     (tgt),
        .imem_busy              (ib),
        .pc_load                (pc_load),
        .pc_target              (pc_target),
        .flush_if_id            (flush_if_id),
        .flush_id_ex            (flush_id_ex),
        .misalign_trap          (misalign_trap),
        .busy                   (busy)
`ifdef REDIRECT_STATS_EN
        ,
        .branch_count           (branch_count),
        .jump_count             (jump_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [36:0] outs(input logic pl, input logic fi, input logic fe,
                                         input logic mt, input logic bz, input logic [31:0] t);
        return {pl, fi, fe, mt, bz, t};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive inputs at a negedge, queue what the outputs must be after the coming posedge.
    task automatic cyc(input string tag, input logic v, input logic b, input logic j,
                       input logic [31:0] t, input logic busy_in, input logic [36:0] e);
        ex_valid = v;
        bj       = b;
        js       = j;
        tgt      = t;
        ib       = busy_in;
        q.push_back('{tag, e});
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            check(x.tag, {27'd0, pc_load, flush_if_id, flush_id_ex, misalign_trap, busy, pc_target},
                  {27'd0, x.v});
        end
    end

    initial begin
        #12;
        check("reset_outs", {27'd0, pc_load, flush_if_id, flush_id_ex, misalign_trap, busy, pc_target}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // simple taken branch, memory free
        cyc("br_redirect", 1, 1, 0, 32'h100, 0, outs(1, 1, 1, 0, 1, 32'h100));
        cyc("br_shadow",   0, 0, 0, 32'h0,   0, outs(0, 1, 0, 0, 1, 32'h100));
        cyc("br_idle",     0, 0, 0, 32'h0,   0, outs(0, 0, 0, 0, 0, 32'h100));
        // fetch busy for three cycles
        cyc("pend1",       1, 1, 0, 32'h200, 1, outs(0, 0, 1, 0, 1, 32'h100));
        cyc("pend2",       0, 0, 0, 32'h0,   1, outs(0, 0, 1, 0, 1, 32'h100));
        cyc("pend3",       1, 1, 0, 32'h300, 1, outs(0, 0, 1, 0, 1, 32'h100));
        cyc("pend_redir",  0, 0, 0, 32'h0,   0, outs(1, 1, 1, 0, 1, 32'h200));
        cyc("pend_shadow", 0, 0, 0, 32'h0,   1, outs(0, 1, 0, 0, 1, 32'h200));
        cyc("pend_idle",   0, 0, 0, 32'h0,   1, outs(0, 0, 0, 0, 0, 32'h200));
        // back-to-back taken: younger ones ignored in REDIRECT and SHADOW
        cyc("b2b_redir",   1, 1, 0, 32'h40,  0, outs(1, 1, 1, 0, 1, 32'h40));
        cyc("b2b_shadow",  1, 1, 0, 32'h80,  0, outs(0, 1, 0, 0, 1, 32'h40));
        cyc("b2b_idle",    1, 1, 0, 32'h80,  0, outs(0, 0, 0, 0, 0, 32'h40));
        cyc("b2b_idle2",   0, 0, 0, 32'h0,   0, outs(0, 0, 0, 0, 0, 32'h40));
        // valid low or not taken: nothing happens
        cyc("not_valid",   0, 1, 0, 32'h500, 0, outs(0, 0, 0, 0, 0, 32'h40));
        cyc("not_taken",   1, 0, 0, 32'h500, 0, outs(0, 0, 0, 0, 0, 32'h40));
        // misaligned jump
        cyc("mis_trap",    1, 1, 1, 32'h102, 0, outs(0, 0, 0, 1, 0, 32'h40));
        cyc("mis_clear",   0, 0, 0, 32'h0,   0, outs(0, 0, 0, 0, 0, 32'h40));
        cyc("mis_busy",    1, 1, 0, 32'h203, 1, outs(0, 0, 0, 1, 0, 32'h40));
        cyc("mis_clear2",  0, 0, 0, 32'h0,   0, outs(0, 0, 0, 0, 0, 32'h40));
        // reset mid-PENDING discards target
        cyc("rst_pend",    1, 1, 0, 32'h300, 1, outs(0, 0, 1, 0, 1, 32'h40));
        #3;
        rst_n = 1'b0;
        ex_valid = 1'b0;
        bj = 1'b0;
        ib = 1'b0;
        #1;
        check("rst_async", {27'd0, pc_load, flush_if_id, flush_id_ex, misalign_trap, busy, pc_target}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("post_rst1",   0, 0, 0, 32'h0,   0, outs(0, 0, 0, 0, 0, 32'h0));
        cyc("post_rst2",   0, 0, 0, 32'h0,   0, outs(0, 0, 0, 0, 0, 32'h0));
        cyc("post_rst3",   0, 0, 0, 32'h0,   0, outs(0, 0, 0, 0, 0, 32'h0));
        // first edge after release evaluates taken
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc("rel_jump",    1, 1, 1, 32'h500, 0, outs(1, 1, 1, 0, 1, 32'h500));
        cyc("rel_shadow",  0, 0, 0, 32'h0,   0, outs(0, 1, 0, 0, 1, 32'h500));
        cyc("rel_idle",    0, 0, 0, 32'h0,   0, outs(0, 0, 0, 0, 0, 32'h500));
        cyc("br2_pend",    1, 1, 0, 32'h600, 1, outs(0, 0, 1, 0, 1, 32'h500));
        cyc("br2_redir",   0, 0, 1, 32'h0,   0, outs(1, 1, 1, 0, 1, 32'h600));
        cyc("br2_shadow",  0, 0, 0, 32'h0,   0, outs(0, 1, 0, 0, 1, 32'h600));
        cyc("br2_idle",    0, 0, 0, 32'h0,   0, outs(0, 0, 0, 0, 0, 32'h600));
        cyc("br3_redir",   1, 1, 0, 32'h700, 0, outs(1, 1, 1, 0, 1, 32'h700));
        cyc("br3_shadow",  0, 0, 0, 32'h0,   0, outs(0, 1, 0, 0, 1, 32'h700));
        cyc("br3_idle",    0, 0, 0, 32'h0,   0, outs(0, 0, 0, 0, 0, 32'h700));
        @(posedge clk);
        #2;
        check("queue_drained", 64'(q.size()), 64'd0);
`ifdef REDIRECT_STATS_EN
        check("branch_count", {32'd0, branch_count}, 64'd2);
        check("jump_count", {32'd0, jump_count}, 64'd1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
